// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks one active-low column at a time, debounces the
// row pattern of the frozen column and reports single-key press/release events.
module keypad_scanner #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 6250,
   parameter int DEB_CYCLES = 250000,
   localparam int KW        = $clog2(ROWS*COLS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ROWS-1:0] row_n,
   output logic [COLS-1:0] col_n,
   output logic [KW-1:0]   key_code,
   output logic            key_valid,
   output logic            key_down,
   output logic            key_release,
   output logic            multi_err
);
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = $clog2(DEB_CYCLES + 1);
   localparam int ZW = $clog2(ROWS + 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   state_t          state;
   logic [ROWS-1:0] rows_m, rows_s, cap_rows;
   logic [CW-1:0]   col_idx, next_col;
   logic [DW-1:0]   dwell_cnt;
   logic [BW-1:0]   deb_cnt;
   logic [ZW-1:0]   zeros;
   logic [RW-1:0]   low_row;
   logic [KW-1:0]   code_calc;
   logic            all_ones;

   // row_n is asynchronous to clk; idle level (all released) is all ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rows_m <= '1;
         rows_s <= '1;
      end else begin
         rows_m <= row_n;
         rows_s <= rows_m;
      end
   end

   always_comb begin
      zeros   = '0;
      low_row = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (!cap_rows[r]) begin
            zeros   = zeros + ZW'(1);
            low_row = RW'(r);
         end
      end
   end

   assign all_ones  = &rows_s;
   assign next_col  = (col_idx == CW'(COLS-1)) ? '0 : col_idx + CW'(1);
   assign code_calc = KW'(low_row) * KW'(COLS) + KW'(col_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SCAN;
         col_idx     <= '0;
         col_n       <= ~COLS'(1);
         dwell_cnt   <= '0;
         deb_cnt     <= '0;
         cap_rows    <= '1;
         key_code    <= '0;
         key_valid   <= 1'b0;
         key_down    <= 1'b0;
         key_release <= 1'b0;
         multi_err   <= 1'b0;
      end else begin
         key_valid   <= 1'b0;
         key_release <= 1'b0;
         multi_err   <= 1'b0;
         case (state)
            SCAN: begin
               if (dwell_cnt == DW'(SCAN_DIV-1)) begin
                  dwell_cnt <= '0;
                  if (all_ones) begin
                     col_idx <= next_col;
                     col_n   <= ~(COLS'(1) << next_col);
                  end else begin
                     cap_rows <= rows_s;
                     deb_cnt  <= '0;
                     state    <= DEBOUNCE;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt + DW'(1);
               end
            end
            DEBOUNCE: begin
               // any change rescans the same column from a fresh dwell
               if (rows_s != cap_rows) begin
                  dwell_cnt <= '0;
                  state     <= SCAN;
               end else if (deb_cnt == BW'(DEB_CYCLES-1)) begin
                  deb_cnt <= '0;
                  state   <= HELD;
                  if (zeros == ZW'(1)) begin
                     key_code  <= code_calc;
                     key_valid <= 1'b1;
                     key_down  <= 1'b1;
                  end else begin
                     multi_err <= 1'b1;
                  end
               end else begin
                  deb_cnt <= deb_cnt + BW'(1);
               end
            end
            HELD: begin
               if (!all_ones) begin
                  deb_cnt <= '0;
               end else if (deb_cnt == BW'(DEB_CYCLES-1)) begin
                  // a multi-key press never raised key_down, so no release event
                  key_release <= key_down;
                  key_down    <= 1'b0;
                  col_idx     <= next_col;
                  col_n       <= ~(COLS'(1) << next_col);
                  dwell_cnt   <= '0;
                  deb_cnt     <= '0;
                  state       <= SCAN;
               end else begin
                  deb_cnt <= deb_cnt + BW'(1);
               end
            end
            default: state <= SCAN;
         endcase
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboarded bench for keypad_scanner: a keypad model drives the rows,
// expected events are queued by the stimulus and checked by a monitor.
module tb_keypad_scanner;
   localparam int ROWS = 4, COLS = 4;

   typedef struct {
      logic [1:0] kind;   // 0 key_valid, 1 key_release, 2 multi_err
      logic [3:0] code;
   } ev_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [ROWS-1:0] row_n;
   logic [COLS-1:0] col_n;
   logic [3:0]      key_code;
   logic            key_valid, key_down, key_release, multi_err;
   logic [ROWS-1:0][COLS-1:0] pressed = '0;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEB_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n), .key_code(key_code),
      .key_valid(key_valid), .key_down(key_down), .key_release(key_release),
      .multi_err(multi_err)
   );

   always #5 clk = ~clk;

   // a pressed key shorts its row to its column while that column is driven
   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         row_n[r] = 1'b1;
         for (int c = 0; c < COLS; c++)
            if (pressed[r][c] && !col_n[c]) row_n[r] = 1'b0;
      end
   end

   always @(negedge clk) begin : monitor
      int   npulse;
      logic [1:0] k;
      ev_t  e;
      if (rst_n) begin
         npulse = int'(key_valid) + int'(key_release) + int'(multi_err);
         if (npulse > 0) begin
            k = key_valid ? 2'd0 : key_release ? 2'd1 : 2'd2;
            checks++;
            if (npulse > 1) begin
               errors++;
               $display("FAIL overlap: %0d event pulses at once, required 1", npulse);
            end else if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: got kind %0d code %0d, required none", k, key_code);
            end else begin
               e = exp_q.pop_front();
               if (e.kind != k || (k != 2'd2 && e.code != key_code)) begin
                  errors++;
                  $display("FAIL event: got kind %0d code %0d, required kind %0d code %0d",
                           k, key_code, e.kind, e.code);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic expect_ev(input logic [1:0] kind, input logic [3:0] code);
      ev_t e;
      e.kind = kind;
      e.code = code;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d events pending after %0d cycles, required 0", name, exp_q.size(), n);
         exp_q.delete();
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [3:0] col_seq [4];
      int n;
      col_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

      // 1: reset state and free-running column walk
      idle(3);
      chk("reset_col_n", col_n, 4'b1110);
      chk("reset_outs", {key_code, key_valid, key_down, key_release, multi_err}, 8'h00);
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k % 4 == 0) chk("col_walk", col_n, col_seq[k/4 - 1]);
      end
      chk("idle_outs", {key_valid, key_down, key_release, multi_err}, 4'h0);

      // 2: clean press and release of (2,1)
      expect_ev(2'd0, 4'd9);
      pressed[2][1] = 1'b1;
      drain("press_21", 200);
      chk("down_21", key_down, 1'b1);
      expect_ev(2'd1, 4'd9);
      pressed[2][1] = 1'b0;
      n = 0;
      while (key_down && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("release_lat_ok", (n >= 16 && n <= 20), 1'b1);
      chk("resume_col2", col_n, 4'b1011);
      drain("release_21", 10);
      idle(30);

      // 3: bouncing press of (0,3), short release bounce
      for (int b = 0; b < 4; b++) begin
         pressed[0][3] = 1'b1;
         idle(5);
         pressed[0][3] = 1'b0;
         idle(5);
      end
      expect_ev(2'd0, 4'd3);
      pressed[0][3] = 1'b1;
      drain("press_03", 200);
      pressed[0][3] = 1'b0;
      idle(10);
      pressed[0][3] = 1'b1;
      idle(20);
      chk("down_03_bounce", key_down, 1'b1);
      expect_ev(2'd1, 4'd3);
      pressed[0][3] = 1'b0;
      drain("release_03", 100);
      idle(30);

      // 4: two rows in one column
      expect_ev(2'd2, 4'd0);
      pressed[1][0] = 1'b1;
      pressed[3][0] = 1'b1;
      drain("multi_10_30", 200);
      chk("multi_down", key_down, 1'b0);
      pressed[1][0] = 1'b0;
      pressed[3][0] = 1'b0;
      n = 0;
      while (col_n != 4'b1101 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("multi_resume_col1", col_n, 4'b1101);
      idle(30);

      // 5: second key ignored while first held, reported after release
      expect_ev(2'd0, 4'd0);
      pressed[0][0] = 1'b1;
      drain("press_00", 200);
      pressed[2][2] = 1'b1;
      idle(100);
      chk("code_held_00", key_code, 4'd0);
      expect_ev(2'd1, 4'd0);
      expect_ev(2'd0, 4'd10);
      pressed[0][0] = 1'b0;
      drain("rollover_22", 300);
      chk("code_22", key_code, 4'd10);
      expect_ev(2'd1, 4'd10);
      pressed[2][2] = 1'b0;
      drain("release_22", 100);
      idle(30);

      // 6: async reset while held
      expect_ev(2'd0, 4'd5);
      pressed[1][1] = 1'b1;
      drain("press_11", 200);
      rst_n = 1'b0;
      #1;
      chk("async_col_n", col_n, 4'b1110);
      chk("async_outs", {key_code, key_valid, key_down, key_release, multi_err}, 8'h00);
      idle(3);
      expect_ev(2'd0, 4'd5);
      rst_n = 1'b1;
      drain("repress_11", 200);
      chk("down_11", key_down, 1'b1);
      expect_ev(2'd1, 4'd5);
      pressed[1][1] = 1'b0;
      drain("release_11", 100);
      idle(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
